mul_reservation_station: RTL and testbench
==========================================

MUL_RESERVATION_STATION -- requirements
Module: mul_reservation_station

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of entries (power of 2, at least 2).
REQ-002 SHALL have parameter ROB_W, default 4, meaning the ROB index width.
REQ-003 SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- dispatch_valid  in  1  dispatch request this cycle.
- dispatch_op  in  mul_op_t  one of reg_mul, reg_mulh, reg_mulsu, reg_mulhu.
- dispatch_rob  in  ROB_W  destination ROB entry.
- dispatch_q1_rdy, dispatch_q2_rdy  in  1  the matching operand value is present.
- dispatch_q1_tag, dispatch_q2_tag  in  ROB_W  producer ROB entry when not ready.
- dispatch_q1_data, dispatch_q2_data  in  32  rs1/rs2 values when ready.
- rs_full  out  1  all entries occupied.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_rob  in  ROB_W  broadcast ROB entry.
- cdb_data  in  32  broadcast value.
- mul_ready  in  1  multiplier can accept an operation.
- mul_done  in  1  multiplier result valid.
- cdb_ready  in  1  CDB accepts the multiplier result.
- start  out  1  issue strobe to the multiplier.
- data  out  rs_mul_output_t  {operation, q1_data, q2_data, rob_dest}.

Function
REQ-004 SHALL write a dispatch into any free entry when dispatch_valid=1 and rs_full=0; the entry is occupied from the next cycle; a dispatch while rs_full=1 SHALL be ignored.
REQ-005 SHALL capture cdb_data into an entry operand on the cycle after any cycle where cdb_valid=1, the entry is occupied, the operand is not ready, and its tag equals cdb_rob; the operand is then ready.
REQ-006 SHALL capture cdb_data at dispatch when an incoming not-ready operand tag equals cdb_rob with cdb_valid=1 in the same cycle.
REQ-007 SHALL run the issue FSM IDLE, ISSUE, RELEASE; reset state is IDLE.
REQ-008 In IDLE, when some occupied entry has both operands ready and mul_ready=1, the FSM SHALL select that entry, register its fields onto data, free the entry, set start=1 and go to ISSUE on the next edge.
REQ-009 In ISSUE, start=1 and data SHALL be held stable; when mul_done=1 and cdb_ready=1, the FSM SHALL go to RELEASE.
REQ-010 In RELEASE, start=0 for exactly one cycle, then the FSM SHALL return to IDLE; minimum spacing between issues is therefore 2 cycles after completion.
REQ-011 Earliest latency: dispatch with both operands ready in cycle 0 SHALL give start=1 in cycle 2.
REQ-012 Dispatch, wakeup and issue selection SHALL all operate in the same cycle without loss; an entry freed by issue SHALL be reusable by dispatch from the next cycle.
REQ-013 rs_full SHALL be combinational from occupancy and SHALL not account for a same-cycle issue.

Reset
REQ-014 On rst, the block SHALL clear all entries to free, set the FSM to IDLE, and set start=0, data='0 and rs_full=0; rst mid-ISSUE SHALL drop start on the next cycle.

Configuration
REQ-015 With MUL_RS_AGE_EN defined, selection SHALL pick the oldest ready entry by dispatch order, using a per-entry age counter of log2(DEPTH) bits.
REQ-016 Without MUL_RS_AGE_EN, selection SHALL pick the lowest-index ready entry, and no age state SHALL exist.

Structure
REQ-017 The shared package rv32i_types SHALL hold mul_op_t, rs_mul_output_t and rs_mul_entry_t.
REQ-018 The selection logic SHALL be the sub-module mul_rs_select, taking ready and age vectors and returning a valid flag and an index.

Verification
REQ-019 Dispatch reg_mul with q1=3 and q2=5, both ready, mul_ready=1 -> start=1 in cycle 2 with data {reg_mul,3,5,rob}.
REQ-020 Dispatch with q1 tag 2 not ready, then cdb_valid with rob 2 and data 0x7 two cycles later -> issue with q1_data=0x7.
REQ-021 Dispatch with q2 tag 5 in the same cycle as a CDB broadcast of rob 5 carrying 0xFFFFFFFF -> entry ready and issues with q2=0xFFFFFFFF.
REQ-022 Fill 4 entries -> rs_full=1 and a fifth dispatch is dropped; after one issue, rs_full=0 the next cycle.
REQ-023 Hold mul_done=1 with cdb_ready=0 for 3 cycles -> start stays 1 with data stable; cdb_ready=1 -> RELEASE with start=0 for 1 cycle.
REQ-024 With MUL_RS_AGE_EN, entries 2 (older) and 0 (newer) become ready together -> entry 2 issues first; without the macro, entry 0 issues first.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I types used by the multiply reservation station: operation encoding,
// issue payload and per-entry storage layout.
package rv32i_types;

    localparam int ROB_IDX_W = 4;

    typedef enum logic [1:0] {
        reg_mul,
        reg_mulh,
        reg_mulsu,
        reg_mulhu
    } mul_op_t;

    typedef struct packed {
        mul_op_t                operation;
        logic [31:0]            q1_data;
        logic [31:0]            q2_data;
        logic [ROB_IDX_W-1:0]   rob_dest;
    } rs_mul_output_t;

    typedef struct packed {
        logic                   valid;
        mul_op_t                operation;
        logic                   q1_rdy;
        logic [ROB_IDX_W-1:0]   q1_tag;
        logic [31:0]            q1_data;
        logic                   q2_rdy;
        logic [ROB_IDX_W-1:0]   q2_tag;
        logic [31:0]            q2_data;
        logic [ROB_IDX_W-1:0]   rob_dest;
    } rs_mul_entry_t;

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_ISSUE,
        RS_RELEASE
    } rs_issue_state_t;

endpackage

// File: rtl/mul_rs_select.sv
// Picks the ready entry with the largest age; ties resolve to the lowest index,
// so an all-zero age vector degenerates to a plain lowest-index priority pick.
module mul_rs_select #(
    parameter int DEPTH = 4,
    parameter int AGE_W = 2
) (
    input  logic [DEPTH-1:0]       ready,
    input  logic [DEPTH*AGE_W-1:0] age,
    output logic                   valid,
    output logic [AGE_W-1:0]       idx
);

    logic [AGE_W-1:0] best_age;

    always_comb begin
        valid    = 1'b0;
        idx      = '0;
        best_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && (!valid || age[i*AGE_W +: AGE_W] > best_age)) begin
                valid    = 1'b1;
                idx      = AGE_W'(i);
                best_age = age[i*AGE_W +: AGE_W];
            end
        end
    end

endmodule

// File: rtl/mul_reservation_station.sv
// Reservation station feeding a single multi-cycle multiplier. Define MUL_RS_AGE_EN
// to issue the oldest ready entry; otherwise the lowest-index ready entry issues.
module mul_reservation_station
    import rv32i_types::*;
#(
    parameter int DEPTH = 4,
    parameter int ROB_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dispatch_valid,
    input  mul_op_t          dispatch_op,
    input  logic [ROB_W-1:0] dispatch_rob,
    input  logic             dispatch_q1_rdy,
    input  logic             dispatch_q2_rdy,
    input  logic [ROB_W-1:0] dispatch_q1_tag,
    input  logic [ROB_W-1:0] dispatch_q2_tag,
    input  logic [31:0]      dispatch_q1_data,
    input  logic [31:0]      dispatch_q2_data,
    output logic             rs_full,
    input  logic             cdb_valid,
    input  logic [ROB_W-1:0] cdb_rob,
    input  logic [31:0]      cdb_data,
    input  logic             mul_ready,
    input  logic             mul_done,
    input  logic             cdb_ready,
    output logic             start,
    output rs_mul_output_t   data
);

    localparam int IDX_W = $clog2(DEPTH);

    rs_mul_entry_t          entries [DEPTH];
    logic [DEPTH-1:0]       occupied;
    logic [DEPTH-1:0]       ready_vec;
    logic [DEPTH*IDX_W-1:0] age_flat;
    logic                   sel_valid;
    logic [IDX_W-1:0]       sel_idx;
    logic [IDX_W-1:0]       alloc_idx;
    logic                   do_dispatch;
    logic                   issue_fire;
    logic                   q1_bypass;
    logic                   q2_bypass;
    rs_issue_state_t        state_q;
    rs_issue_state_t        state_next;

    always_comb begin
        occupied  = '0;
        ready_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupied[i]  = entries[i].valid;
            ready_vec[i] = entries[i].valid && entries[i].q1_rdy && entries[i].q2_rdy;
        end
    end

    assign rs_full = &occupied;

    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!occupied[i]) alloc_idx = IDX_W'(i);
        end
    end

    assign do_dispatch = dispatch_valid && !rs_full;
    assign issue_fire  = (state_q == RS_IDLE) && sel_valid && mul_ready;
    // A producer broadcasting in the dispatch cycle would otherwise be missed forever.
    assign q1_bypass   = cdb_valid && !dispatch_q1_rdy && (dispatch_q1_tag == cdb_rob);
    assign q2_bypass   = cdb_valid && !dispatch_q2_rdy && (dispatch_q2_tag == cdb_rob);

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                entries[i].valid <= 1'b0;
            end else if (do_dispatch && alloc_idx == IDX_W'(i)) begin
                entries[i] <= '{valid:     1'b1,
                                operation: dispatch_op,
                                q1_rdy:    dispatch_q1_rdy || q1_bypass,
                                q1_tag:    dispatch_q1_tag,
                                q1_data:   dispatch_q1_rdy ? dispatch_q1_data : cdb_data,
                                q2_rdy:    dispatch_q2_rdy || q2_bypass,
                                q2_tag:    dispatch_q2_tag,
                                q2_data:   dispatch_q2_rdy ? dispatch_q2_data : cdb_data,
                                rob_dest:  dispatch_rob};
            end else if (issue_fire && sel_idx == IDX_W'(i)) begin
                entries[i].valid <= 1'b0;
            end else if (entries[i].valid && cdb_valid) begin
                if (!entries[i].q1_rdy && entries[i].q1_tag == cdb_rob) begin
                    entries[i].q1_rdy  <= 1'b1;
                    entries[i].q1_data <= cdb_data;
                end
                if (!entries[i].q2_rdy && entries[i].q2_tag == cdb_rob) begin
                    entries[i].q2_rdy  <= 1'b1;
                    entries[i].q2_data <= cdb_data;
                end
            end
        end
    end

`ifdef MUL_RS_AGE_EN
    // Ages are kept as a dense rank (0 = newest), so log2(DEPTH) bits never overflow.
    logic [IDX_W-1:0] age [DEPTH];
    logic [IDX_W-1:0] sel_age;

    assign sel_age = age[sel_idx];

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (do_dispatch && alloc_idx == IDX_W'(i)) begin
                age[i] <= '0;
            end else if (occupied[i]) begin
                age[i] <= age[i] - IDX_W'(issue_fire && (age[i] > sel_age))
                                 + IDX_W'(do_dispatch);
            end
        end
    end

    always_comb begin
        age_flat = '0;
        for (int i = 0; i < DEPTH; i++) age_flat[i*IDX_W +: IDX_W] = age[i];
    end
`else
    assign age_flat = '0;
`endif

    mul_rs_select #(
        .DEPTH (DEPTH),
        .AGE_W (IDX_W)
    ) u_select (
        .ready (ready_vec),
        .age   (age_flat),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= RS_IDLE;
        else     state_q <= state_next;
    end

    always_comb begin
        state_next = state_q;
        start      = 1'b0;
        case (state_q)
            RS_IDLE:    if (issue_fire) state_next = RS_ISSUE;
            RS_ISSUE: begin
                start = 1'b1;
                if (mul_done && cdb_ready) state_next = RS_RELEASE;
            end
            RS_RELEASE: state_next = RS_IDLE;
            default:    state_next = RS_IDLE;
        endcase
    end

    // Issue payload is held until the next issue so it stays stable through ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (issue_fire) begin
            data <= '{operation: entries[sel_idx].operation,
                      q1_data:   entries[sel_idx].q1_data,
                      q2_data:   entries[sel_idx].q2_data,
                      rob_dest:  entries[sel_idx].rob_dest};
        end
    end

endmodule

// File: tb/tb_mul_reservation_station.sv
// Directed bench for mul_reservation_station; expected payloads are hand-built per vector.
module tb_mul_reservation_station;
    import rv32i_types::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           dispatch_valid;
    mul_op_t        dispatch_op;
    logic [3:0]     dispatch_rob;
    logic           dispatch_q1_rdy, dispatch_q2_rdy;
    logic [3:0]     dispatch_q1_tag, dispatch_q2_tag;
    logic [31:0]    dispatch_q1_data, dispatch_q2_data;
    logic           rs_full;
    logic           cdb_valid;
    logic [3:0]     cdb_rob;
    logic [31:0]    cdb_data;
    logic           mul_ready, mul_done, cdb_ready;
    logic           start;
    rs_mul_output_t data;

    int n_vec = 0;
    int n_bad = 0;

    mul_reservation_station #(.DEPTH(4), .ROB_W(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .dispatch_valid   (dispatch_valid),
        .dispatch_op      (dispatch_op),
        .dispatch_rob     (dispatch_rob),
        .dispatch_q1_rdy  (dispatch_q1_rdy),
        .dispatch_q2_rdy  (dispatch_q2_rdy),
        .dispatch_q1_tag  (dispatch_q1_tag),
        .dispatch_q2_tag  (dispatch_q2_tag),
        .dispatch_q1_data (dispatch_q1_data),
        .dispatch_q2_data (dispatch_q2_data),
        .rs_full          (rs_full),
        .cdb_valid        (cdb_valid),
        .cdb_rob          (cdb_rob),
        .cdb_data         (cdb_data),
        .mul_ready        (mul_ready),
        .mul_done         (mul_done),
        .cdb_ready        (cdb_ready),
        .start            (start),
        .data             (data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input mul_op_t op, input logic r1, input logic [3:0] t1,
                        input logic [31:0] d1, input logic r2, input logic [3:0] t2,
                        input logic [31:0] d2, input logic [3:0] rob);
        dispatch_valid   = 1'b1;
        dispatch_op      = op;
        dispatch_q1_rdy  = r1;
        dispatch_q1_tag  = t1;
        dispatch_q1_data = d1;
        dispatch_q2_rdy  = r2;
        dispatch_q2_tag  = t2;
        dispatch_q2_data = d2;
        dispatch_rob     = rob;
    endtask

    task automatic idle_inputs;
        dispatch_valid = 1'b0;
        cdb_valid      = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle_inputs();
        mul_ready = 1'b0;
        mul_done  = 1'b0;
        cdb_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic complete(input string tag);
        mul_done  = 1'b1;
        cdb_ready = 1'b1;
        tick();
        mul_done  = 1'b0;
        cdb_ready = 1'b0;
        chk(tag, 128'(start), 128'(1'b0));
        tick();
    endtask

    task automatic wait_start(input string tag, input rs_mul_output_t exp);
        int n = 0;
        while (!start && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 128'(start), 128'(1'b1));
        chk({tag, "_data"}, 128'(data), 128'(exp));
    endtask

    initial begin
        rs_mul_output_t exp;
        rs_mul_output_t held;
        dispatch_op = reg_mul; dispatch_rob = '0;
        dispatch_q1_rdy = 0; dispatch_q2_rdy = 0; dispatch_q1_tag = '0; dispatch_q2_tag = '0;
        dispatch_q1_data = '0; dispatch_q2_data = '0; cdb_rob = '0; cdb_data = '0;
        do_reset();
        tick();
        chk("rst_start", 128'(start), 128'(1'b0));
        chk("rst_full", 128'(rs_full), 128'(1'b0));
        chk("rst_data", 128'(data), 128'(0));

        // Both operands ready at dispatch: start in cycle 2.
        mul_ready = 1'b1;
        disp(reg_mul, 1, 0, 32'd3, 1, 0, 32'd5, 4'd1);
        tick();
        idle_inputs();
        chk("lat_c1_start", 128'(start), 128'(1'b0));
        tick();
        chk("lat_c2_start", 128'(start), 128'(1'b1));
        exp = '{operation: reg_mul, q1_data: 32'd3, q2_data: 32'd5, rob_dest: 4'd1};
        chk("lat_data", 128'(data), 128'(exp));
        complete("lat_release");

        // Wakeup from a later CDB broadcast.
        do_reset();
        mul_ready = 1'b1;
        disp(reg_mulh, 0, 4'd2, 32'd0, 1, 0, 32'h10, 4'd3);
        tick();
        idle_inputs();
        tick();
        cdb_valid = 1'b1; cdb_rob = 4'd2; cdb_data = 32'h7;
        chk("wake_c2_start", 128'(start), 128'(1'b0));
        tick();
        cdb_valid = 1'b0;
        chk("wake_c3_start", 128'(start), 128'(1'b0));
        tick();
        chk("wake_c4_start", 128'(start), 128'(1'b1));
        exp = '{operation: reg_mulh, q1_data: 32'h7, q2_data: 32'h10, rob_dest: 4'd3};
        chk("wake_data", 128'(data), 128'(exp));
        complete("wake_release");

        // Broadcast in the dispatch cycle is captured directly.
        do_reset();
        mul_ready = 1'b1;
        disp(reg_mulhu, 1, 0, 32'd2, 0, 4'd5, 32'd0, 4'd4);
        cdb_valid = 1'b1; cdb_rob = 4'd5; cdb_data = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        tick();
        chk("byp_start", 128'(start), 128'(1'b1));
        exp = '{operation: reg_mulhu, q1_data: 32'd2, q2_data: 32'hFFFF_FFFF, rob_dest: 4'd4};
        chk("byp_data", 128'(data), 128'(exp));
        complete("byp_release");

        // Fill, drop a fifth dispatch, then hold ISSUE while the CDB stalls.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            chk("fill_not_full", 128'(rs_full), 128'(1'b0));
            disp(reg_mul, 1, 0, 32'(i + 1), 1, 0, 32'd10, 4'(8 + i));
            tick();
        end
        chk("fill_full", 128'(rs_full), 128'(1'b1));
        disp(reg_mulsu, 1, 0, 32'd99, 1, 0, 32'd99, 4'd12);
        tick();
        idle_inputs();
        mul_ready = 1'b1;
        chk("full_same_cycle", 128'(rs_full), 128'(1'b1));
        tick();
        chk("full_after_issue", 128'(rs_full), 128'(1'b0));
        chk("full_issue_start", 128'(start), 128'(1'b1));
        exp = '{operation: reg_mul, q1_data: 32'd1, q2_data: 32'd10, rob_dest: 4'd8};
        chk("full_issue_data", 128'(data), 128'(exp));
        held = data;
        mul_done = 1'b1; cdb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_start", 128'(start), 128'(1'b1));
            chk("stall_data", 128'(data), 128'(held));
        end
        cdb_ready = 1'b1;
        tick();
        mul_done = 1'b0; cdb_ready = 1'b0;
        chk("stall_release", 128'(start), 128'(1'b0));
        tick();
        chk("stall_idle", 128'(start), 128'(1'b0));
        tick();
        exp = '{operation: reg_mul, q1_data: 32'd2, q2_data: 32'd10, rob_dest: 4'd9};
        chk("drain1_start", 128'(start), 128'(1'b1));
        chk("drain1_data", 128'(data), 128'(exp));
        complete("drain1_release");
        exp = '{operation: reg_mul, q1_data: 32'd3, q2_data: 32'd10, rob_dest: 4'd10};
        wait_start("drain2", exp);
        complete("drain2_release");
        exp = '{operation: reg_mul, q1_data: 32'd4, q2_data: 32'd10, rob_dest: 4'd11};
        wait_start("drain3", exp);
        complete("drain3_release");
        for (int i = 0; i < 4; i++) tick();
        chk("dropped_no_issue", 128'(start), 128'(1'b0));

        // Entry 2 older than entry 0; both woken by the same broadcast.
        do_reset();
        disp(reg_mul, 0, 4'd6, 0, 1, 0, 32'd1, 4'd1);
        tick();
        disp(reg_mul, 0, 4'd9, 0, 1, 0, 32'd2, 4'd2);
        tick();
        disp(reg_mul, 0, 4'd7, 0, 1, 0, 32'd3, 4'd3);
        tick();
        idle_inputs();
        cdb_valid = 1'b1; cdb_rob = 4'd6; cdb_data = 32'h20;
        tick();
        cdb_valid = 1'b0;
        mul_ready = 1'b1;
        tick();
        mul_ready = 1'b0;
        chk("age_first_start", 128'(start), 128'(1'b1));
        exp = '{operation: reg_mul, q1_data: 32'h20, q2_data: 32'd1, rob_dest: 4'd1};
        chk("age_first_data", 128'(data), 128'(exp));
        complete("age_first_release");
        disp(reg_mul, 0, 4'd7, 0, 1, 0, 32'd4, 4'd5);
        tick();
        idle_inputs();
        cdb_valid = 1'b1; cdb_rob = 4'd7; cdb_data = 32'h33;
        tick();
        cdb_valid = 1'b0;
        mul_ready = 1'b1;
        tick();
        chk("age_pick_start", 128'(start), 128'(1'b1));
`ifdef MUL_RS_AGE_EN
        exp = '{operation: reg_mul, q1_data: 32'h33, q2_data: 32'd3, rob_dest: 4'd3};
`else
        exp = '{operation: reg_mul, q1_data: 32'h33, q2_data: 32'd4, rob_dest: 4'd5};
`endif
        chk("age_pick_data", 128'(data), 128'(exp));
        complete("age_pick_release");
`ifdef MUL_RS_AGE_EN
        exp = '{operation: reg_mul, q1_data: 32'h33, q2_data: 32'd4, rob_dest: 4'd5};
`else
        exp = '{operation: reg_mul, q1_data: 32'h33, q2_data: 32'd3, rob_dest: 4'd3};
`endif
        wait_start("age_second", exp);

        // Reset while in ISSUE.
        rst = 1'b1;
        mul_ready = 1'b0;
        tick();
        rst = 1'b0;
        chk("midrst_start", 128'(start), 128'(1'b0));
        chk("midrst_full", 128'(rs_full), 128'(1'b0));
        chk("midrst_data", 128'(data), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
